des_block_sequencer: RTL and testbench

//  Sequences the DES round core over a run of 64-bit blocks held in a 32-bit-wide input block RAM.

---
 rtl/des_block_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_des_block_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_block_sequencer.sv
// -----------------------------------------------------------------------------
// des_block_sequencer
//
// Purpose:
//   Walks a run of 64-bit blocks stored as pairs of 32-bit words in an input
//   block RAM, feeds each block through an external iterative DES round core,
//   and writes the results as word pairs into an output block RAM.
//   ECB and CBC chaining are supported (encrypt and decrypt). All addressing
//   wraps modulo 2**ADDR_W.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start, abort          1-cycle host triggers
//   decrypt, cbc_en, iv,
//   blk_count, in_base,
//   out_base              run configuration, sampled on an accepted start
//   ramI_addr / ramI_dout input RAM read port (1-cycle read latency)
//   ramO_addr / ramO_din /
//   ramO_write            output RAM write port
//   des_in, des_round,
//   des_decrypt / des_out DES round core interface
//   busy, done,
//   blocks_done           run status
// -----------------------------------------------------------------------------
module des_block_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int NROUNDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              decrypt,
    input  logic              cbc_en,
    input  logic [63:0]       iv,
    input  logic [ADDR_W-2:0] blk_count,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] ramI_addr,
    input  logic [31:0]       ramI_dout,
    output logic [ADDR_W-1:0] ramO_addr,
    output logic [31:0]       ramO_din,
    output logic              ramO_write,
    output logic [63:0]       des_in,
    output logic [3:0]        des_round,
    output logic              des_decrypt,
    input  logic [63:0]       des_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] blocks_done
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD0   = 4'd1,
        S_RD1   = 4'd2,
        S_RD2   = 4'd3,
        S_ROUND = 4'd4,
        S_WR0   = 4'd5,
        S_WR1   = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [3:0]        LAST_ROUND = 4'(NROUNDS - 1);
    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);

    state_t              state_q, state_d;
    logic                decrypt_q, decrypt_d;
    logic                cbc_q, cbc_d;
    logic [63:0]         chain_q, chain_d;
    logic [ADDR_W-2:0]   blk_cnt_q, blk_cnt_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]         lo_q, lo_d;
    logic [63:0]         blk_q, blk_d;
    logic [63:0]         des_in_q, des_in_d;
    logic [3:0]          round_q, round_d;
    logic [63:0]         res_q, res_d;
    logic [ADDR_W-1:0]   blocks_done_q, blocks_done_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ramO_write_q, ramO_write_d;
    logic [31:0]         ramO_din_q, ramO_din_d;

    logic                abort_run_s;
    logic [ADDR_W-1:0]   target_s;

    // An abort only matters once a run is in flight; in IDLE it merely vetoes start.
    assign abort_run_s = abort && (state_q != S_IDLE);
    // Number of blocks in the run (blk_count holds blocks minus one).
    assign target_s    = {1'b0, blk_cnt_q} + ONE_A;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        decrypt_d     = decrypt_q;
        cbc_d         = cbc_q;
        chain_d       = chain_q;
        blk_cnt_d     = blk_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        lo_d          = lo_q;
        blk_d         = blk_q;
        des_in_d      = des_in_q;
        round_d       = round_q;
        res_d         = res_q;
        blocks_done_d = blocks_done_q;

        if (abort_run_s) begin
            // Drop the run; pointers, counters and chain simply hold.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        decrypt_d     = decrypt;
                        cbc_d         = cbc_en;
                        chain_d       = iv;
                        blk_cnt_d     = blk_count;
                        rd_ptr_d      = in_base;
                        wr_ptr_d      = out_base;
                        blocks_done_d = '0;
                        state_d       = S_RD0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RD0: begin
                    rd_ptr_d = rd_ptr_q + ONE_A;
                    state_d  = S_RD1;
                end
                S_RD1: begin
                    lo_d     = ramI_dout;
                    rd_ptr_d = rd_ptr_q + ONE_A;
                    state_d  = S_RD2;
                end
                S_RD2: begin
                    blk_d    = {ramI_dout, lo_q};
                    // CBC encrypt whitens the plaintext with the previous ciphertext.
                    if (cbc_q && !decrypt_q) begin
                        des_in_d = blk_d ^ chain_q;
                    end else begin
                        des_in_d = blk_d;
                    end
                    round_d  = 4'd0;
                    state_d  = S_ROUND;
                end
                S_ROUND: begin
                    if (round_q == LAST_ROUND) begin
                        if (cbc_q && decrypt_q) begin
                            res_d = des_out ^ chain_q;
                        end else begin
                            res_d = des_out;
                        end
                        // The chain always carries the ciphertext of this block.
                        if (cbc_q) begin
                            chain_d = decrypt_q ? blk_q : des_out;
                        end else begin
                            chain_d = chain_q;
                        end
                        round_d = 4'd0;
                        state_d = S_WR0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                S_WR0: begin
                    wr_ptr_d = wr_ptr_q + ONE_A;
                    state_d  = S_WR1;
                end
                S_WR1: begin
                    wr_ptr_d      = wr_ptr_q + ONE_A;
                    blocks_done_d = blocks_done_q + ONE_A;
                    state_d       = S_NEXT;
                end
                S_NEXT: begin
                    if (blocks_done_q == target_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered against the state being entered, so they
        // line up with that state and vanish the cycle after an abort.
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        ramO_write_d = (state_d == S_WR0) || (state_d == S_WR1);
        case (state_d)
            S_WR0:   ramO_din_d = res_d[31:0];
            S_WR1:   ramO_din_d = res_d[63:32];
            default: ramO_din_d = 32'd0;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            decrypt_q     <= 1'b0;
            cbc_q         <= 1'b0;
            chain_q       <= 64'd0;
            blk_cnt_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            lo_q          <= 32'd0;
            blk_q         <= 64'd0;
            des_in_q      <= 64'd0;
            round_q       <= 4'd0;
            res_q         <= 64'd0;
            blocks_done_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ramO_write_q  <= 1'b0;
            ramO_din_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            decrypt_q     <= decrypt_d;
            cbc_q         <= cbc_d;
            chain_q       <= chain_d;
            blk_cnt_q     <= blk_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            lo_q          <= lo_d;
            blk_q         <= blk_d;
            des_in_q      <= des_in_d;
            round_q       <= round_d;
            res_q         <= res_d;
            blocks_done_q <= blocks_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ramO_write_q  <= ramO_write_d;
            ramO_din_q    <= ramO_din_d;
        end
    end

    // The read pointer doubles as the RAM address: it holds the word being
    // fetched during RD0/RD1 and advances once that address has been issued.
    assign ramI_addr   = rd_ptr_q;
    assign ramO_addr   = wr_ptr_q;
    assign ramO_din    = ramO_din_q;
    assign ramO_write  = ramO_write_q;
    assign des_in      = des_in_q;
    assign des_round   = round_q;
    assign des_decrypt = decrypt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_des_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_block_sequencer
//
// Surrounds the sequencer with a synchronous-read input RAM and a stand-in
// block cipher (an invertible rotate/xor/add mix) that only presents a
// valid result on the final round. Expected RAM writes come from a reference
// model of ECB/CBC chaining and are queued; a monitor pops and compares on
// every write the DUT makes.
// -----------------------------------------------------------------------------
module tb_des_block_sequencer;

    localparam int AW = 9;
    localparam int DEPTH = 512;
    localparam logic [63:0] K1 = 64'hA5C3_1F27_9E4B_6D80;
    localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;

    logic          clk = 1'b0;
    logic          reset, start, abort, decrypt, cbc_en;
    logic [63:0]   iv;
    logic [AW-2:0] blk_count;
    logic [AW-1:0] in_base, out_base;
    logic [AW-1:0] ramI_addr, ramO_addr, blocks_done;
    logic [31:0]   ramI_dout, ramO_din;
    logic          ramO_write, des_decrypt, busy, done;
    logic [63:0]   des_in, des_out;
    logic [3:0]    des_round;

    logic [31:0]   mem_i [0:DEPTH-1];
    logic [40:0]   exp_q [$];
    logic [63:0]   mdl_out [$];
    logic [40:0]   mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int n_wr = 0;

    des_block_sequencer #(.ADDR_W(AW), .NROUNDS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .decrypt(decrypt), .cbc_en(cbc_en), .iv(iv), .blk_count(blk_count),
        .in_base(in_base), .out_base(out_base),
        .ramI_addr(ramI_addr), .ramI_dout(ramI_dout),
        .ramO_addr(ramO_addr), .ramO_din(ramO_din), .ramO_write(ramO_write),
        .des_in(des_in), .des_round(des_round), .des_decrypt(des_decrypt),
        .des_out(des_out), .busy(busy), .done(done), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] toy_enc(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ K1;
        return {t[50:0], t[63:51]} + K2;
    endfunction

    function automatic logic [63:0] toy_dec(input logic [63:0] y);
        logic [63:0] t;
        t = y - K2;
        return {t[12:0], t[63:13]} ^ K1;
    endfunction

    // Stand-in cipher: result only valid on the last round.
    assign des_out = (des_round == 4'd15) ? (des_decrypt ? toy_dec(des_in) : toy_enc(des_in))
                                          : 64'hBAD0_BAD0_BAD0_BAD0;

    // Input RAM, one-cycle read latency.
    always @(posedge clk) ramI_dout <= mem_i[ramI_addr];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (ramO_write === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", ramO_addr, ramO_din);
            end else begin
                mon_e = exp_q.pop_front();
                check("ram_write", {23'd0, ramO_addr, ramO_din}, {23'd0, mon_e});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    // Reference model: push the expected word writes for the first nblk blocks.
    task automatic push_expected(input bit dec, input bit cbc, input logic [63:0] ivv,
                                 input int nblk, input int ib, input int ob);
        logic [63:0] ch, p, r;
        ch = ivv;
        mdl_out.delete();
        for (int k = 0; k < nblk; k++) begin
            p = {mem_i[(ib + 2*k + 1) % DEPTH], mem_i[(ib + 2*k) % DEPTH]};
            if (!cbc) begin
                r = dec ? toy_dec(p) : toy_enc(p);
            end else if (!dec) begin
                r = toy_enc(p ^ ch);
                ch = r;
            end else begin
                r = toy_dec(p) ^ ch;
                ch = p;
            end
            exp_q.push_back({9'((ob + 2*k) % DEPTH), r[31:0]});
            exp_q.push_back({9'((ob + 2*k + 1) % DEPTH), r[63:32]});
            mdl_out.push_back(r);
        end
    endtask

    task automatic drive_cfg(input bit dec, input bit cbc, input logic [63:0] ivv,
                             input logic [7:0] cnt, input logic [8:0] ib, input logic [8:0] ob);
        decrypt = dec; cbc_en = cbc; iv = ivv; blk_count = cnt; in_base = ib; out_base = ob;
    endtask

    task automatic scramble_cfg;
        decrypt = 1'($urandom); cbc_en = 1'($urandom); iv = {$urandom, $urandom};
        blk_count = 8'($urandom); in_base = 9'($urandom); out_base = 9'($urandom);
    endtask

    // Start a run, disturb the config, optionally re-pulse start mid-run,
    // and wait (bounded) for done. cyc = negedges from start drive to done.
    task automatic run_job(input bit dec, input bit cbc, input logic [63:0] ivv,
                           input logic [7:0] cnt, input logic [8:0] ib, input logic [8:0] ob,
                           input int poke_at, output int cyc);
        drive_cfg(dec, cbc, ivv, cnt, ib, ob);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        cyc = 1;
        while (done !== 1'b1 && cyc < 22 * (int'(cnt) + 1) + 40) begin
            start = (cyc == poke_at);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("done_seen", {63'd0, done}, 64'd1);
        tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl_a"}, {14'd0, ramI_addr, ramO_addr, ramO_din}, 64'd0);
        check({tag, "_ctl_b"}, {47'd0, ramO_write, des_round, des_decrypt, busy, done, blocks_done}, 64'd0);
        check({tag, "_des_in"}, des_in, 64'd0);
    endtask

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time bound reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, d0, w0;
        bit dec, cbc;
        logic [63:0] ivv;
        logic [7:0] cnt;
        logic [8:0] ib, ob;
        logic [63:0] plain [$];

        for (int i = 0; i < DEPTH; i++) mem_i[i] = $urandom;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        drive_cfg(1'b0, 1'b0, 64'd0, 8'd0, 9'd0, 9'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_zero_outputs("reset");

        // 1: ECB encrypt, one block, bases 0: latency and exactly two writes.
        mem_i[0] = 32'h89AB_CDEF; mem_i[1] = 32'h0123_4567;
        w0 = n_wr; d0 = done_cnt;
        push_expected(1'b0, 1'b0, 64'd0, 1, 0, 0);
        run_job(1'b0, 1'b0, 64'd0, 8'd0, 9'd0, 9'd0, 0, cyc);
        check("t1_latency", 64'(cyc), 64'd23);
        check("t1_writes", 64'(n_wr - w0), 64'd2);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t1_busy_after", {63'd0, busy}, 64'd0);

        // 2: CBC encrypt 4 blocks, then CBC decrypt of the ciphertext.
        ivv = {$urandom, $urandom};
        push_expected(1'b0, 1'b1, ivv, 4, 100, 200);
        plain.delete();
        for (int k = 0; k < 4; k++) plain.push_back({mem_i[100 + 2*k + 1], mem_i[100 + 2*k]});
        for (int k = 0; k < 4; k++) begin
            mem_i[300 + 2*k]     = mdl_out[k][31:0];
            mem_i[300 + 2*k + 1] = mdl_out[k][63:32];
        end
        run_job(1'b0, 1'b1, ivv, 8'd3, 9'd100, 9'd200, 0, cyc);
        check("t2_enc_blocks", 64'(blocks_done), 64'd4);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({9'(240 + 2*k), plain[k][31:0]});
            exp_q.push_back({9'(240 + 2*k + 1), plain[k][63:32]});
        end
        run_job(1'b1, 1'b1, ivv, 8'd3, 9'd300, 9'd240, 0, cyc);
        check("t2_dec_blocks", 64'(blocks_done), 64'd4);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: wrap around the top of both RAMs.
        push_expected(1'b0, 1'b1, 64'h1122_3344_5566_7788, 2, 510, 510);
        run_job(1'b0, 1'b1, 64'h1122_3344_5566_7788, 8'd1, 9'd510, 9'd510, 0, cyc);
        check("t3_blocks_done", 64'(blocks_done), 64'd2);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: abort in the third ROUND cycle of block 2.
        d0 = done_cnt;
        push_expected(1'b1, 1'b0, 64'd0, 1, 50, 60);
        drive_cfg(1'b1, 1'b0, 64'd0, 8'd3, 9'd50, 9'd60);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        check("t4_round_at_abort", 64'(des_round), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy_low", {63'd0, busy}, 64'd0);
        check("t4_blocks_done", 64'(blocks_done), 64'd1);
        repeat (30) tick();
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: start while busy is ignored; start+abort in IDLE does nothing.
        d0 = done_cnt;
        push_expected(1'b0, 1'b0, 64'd0, 1, 20, 30);
        run_job(1'b0, 1'b0, 64'd0, 8'd0, 9'd20, 9'd30, 5, cyc);
        check("t5_latency", 64'(cyc), 64'd23);
        repeat (30) tick();
        check("t5_one_done", 64'(done_cnt - d0), 64'd1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (4) tick();
        check("t5_no_run_busy", {63'd0, busy}, 64'd0);
        check("t5_blocks_kept", 64'(blocks_done), 64'd1);

        // 6: reset during WR0.
        push_expected(1'b0, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1, 70, 80);
        void'(exp_q.pop_back());
        drive_cfg(1'b0, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 8'd2, 9'd70, 9'd80);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("t6_in_wr0", {63'd0, ramO_write}, 64'd1);
        reset = 1'b1;
        tick();
        check_zero_outputs("t6_after_reset");
        reset = 1'b0;
        tick();
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        // Randomized runs (the first also restarts cleanly after the reset).
        for (int r = 0; r < 6; r++) begin
            dec = 1'($urandom); cbc = 1'($urandom); ivv = {$urandom, $urandom};
            cnt = 8'($urandom_range(0, 4)); ib = 9'($urandom); ob = 9'($urandom);
            push_expected(dec, cbc, ivv, int'(cnt) + 1, int'(ib), int'(ob));
            run_job(dec, cbc, ivv, cnt, ib, ob, 0, cyc);
            check("rand_latency", 64'(cyc), 64'(22 * (int'(cnt) + 1) + 1));
            check("rand_blocks_done", 64'(blocks_done), 64'(int'(cnt) + 1));
            check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
